// File: rtl/arith_pipe_unit.sv
// arith_pipe_unit: registered add/sub/accumulate unit with valid/ready on both sides.
// Ports: clk, rst_n (async, active-low); In_valid/In_ready/A/B/Op/Acc_clear (operand side);
// Out_valid/Out_ready/Result/CarryOut/Overflow/Zero/Negative (result side); Acc; Op_count.
module arith_pipe_unit #(
  parameter int WIDTH     = 4,
  parameter bit SATURATE  = 1'b0,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 In_valid,
  output logic                 In_ready,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic [1:0]           Op,
  input  logic                 Acc_clear,
  output logic                 Out_valid,
  input  logic                 Out_ready,
  output logic [WIDTH-1:0]     Result,
  output logic                 CarryOut,
  output logic                 Overflow,
  output logic                 Zero,
  output logic                 Negative,
  output logic [WIDTH-1:0]     Acc,
  output logic [CNT_WIDTH-1:0] Op_count
);

  typedef enum logic [1:0] {
    OP_ADD     = 2'b00,
    OP_SUB     = 2'b01,
    OP_ACC_ADD = 2'b10,
    OP_ACC_SUB = 2'b11
  } op_e;

  op_e              op_dec;
  logic             is_acc;
  logic             is_sub;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH:0]   raw;
  logic             ovf;
  logic [WIDTH-1:0] final_res;
  logic             accept;
  logic             consume;
  logic [WIDTH-1:0] acc_q;

  assign op_dec   = op_e'(Op);
  assign In_ready = !Out_valid || Out_ready;
  assign accept   = In_valid && In_ready;
  assign consume  = Out_valid && Out_ready;
  assign Acc      = acc_q;

  always_comb begin
    is_acc = (op_dec == OP_ACC_ADD) || (op_dec == OP_ACC_SUB);
    is_sub = (op_dec == OP_SUB)     || (op_dec == OP_ACC_SUB);
    // A same-cycle clear makes the accumulator operand read as zero.
    opa = is_acc ? (Acc_clear ? '0 : acc_q) : A;
    opb = is_acc ? A : B;
    if (is_sub) begin
      raw = {1'b0, opa} - {1'b0, opb};
      ovf = (opa[WIDTH-1] != opb[WIDTH-1]) && (raw[WIDTH-1] != opa[WIDTH-1]);
    end else begin
      raw = {1'b0, opa} + {1'b0, opb};
      ovf = (opa[WIDTH-1] == opb[WIDTH-1]) && (raw[WIDTH-1] != opa[WIDTH-1]);
    end
    final_res = raw[WIDTH-1:0];
    if (SATURATE && ovf) begin
      final_res = opa[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Out_valid <= 1'b0;
      Result    <= '0;
      CarryOut  <= 1'b0;
      Overflow  <= 1'b0;
      Zero      <= 1'b0;
      Negative  <= 1'b0;
    end else if (accept) begin
      Out_valid <= 1'b1;
      Result    <= final_res;
      CarryOut  <= raw[WIDTH];
      Overflow  <= ovf;
      Zero      <= (final_res == '0);
      Negative  <= final_res[WIDTH-1];
    end else if (consume) begin
      Out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (accept && is_acc) begin
      acc_q <= final_res;
    end else if (Acc_clear) begin
      acc_q <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Op_count <= '0;
    end else if (consume && (Op_count != '1)) begin
      Op_count <= Op_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_arith_pipe_unit.sv
module tb_arith_pipe_unit;

  typedef struct packed {
    logic [3:0] res;
    logic       c;
    logic       v;
    logic       z;
    logic       n;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] a;
  logic [3:0] b;
  logic [1:0] op;
  logic       clr;
  logic       out_ready;

  logic       In_ready0, Out_valid0, CarryOut0, Overflow0, Zero0, Negative0;
  logic [3:0] Result0, Acc0;
  logic [7:0] Op_count0;
  logic       In_ready1, Out_valid1, CarryOut1, Overflow1, Zero1, Negative1;
  logic [3:0] Result1, Acc1;
  logic [2:0] Op_count1;

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  exp_t q0[$];
  exp_t q1[$];
  logic       m_valid;
  logic [3:0] m_acc0, m_acc1;
  int         m_cnt0, m_cnt1;
  int         cnt_snap;

  arith_pipe_unit #(.WIDTH(4), .SATURATE(1'b0), .CNT_WIDTH(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .In_valid(in_valid), .In_ready(In_ready0),
    .A(a), .B(b), .Op(op), .Acc_clear(clr), .Out_valid(Out_valid0),
    .Out_ready(out_ready), .Result(Result0), .CarryOut(CarryOut0),
    .Overflow(Overflow0), .Zero(Zero0), .Negative(Negative0), .Acc(Acc0),
    .Op_count(Op_count0)
  );

  arith_pipe_unit #(.WIDTH(4), .SATURATE(1'b1), .CNT_WIDTH(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .In_valid(in_valid), .In_ready(In_ready1),
    .A(a), .B(b), .Op(op), .Acc_clear(clr), .Out_valid(Out_valid1),
    .Out_ready(out_ready), .Result(Result1), .CarryOut(CarryOut1),
    .Overflow(Overflow1), .Zero(Zero1), .Negative(Negative1), .Acc(Acc1),
    .Op_count(Op_count1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Independent integer model of one operation.
  function automatic exp_t calc(input logic [1:0] o, input logic [3:0] av, input logic [3:0] bv,
                                input logic [3:0] accv, input bit sat);
    int x, y, sx, sy, ur, sr, r;
    exp_t e;
    x  = o[1] ? int'(accv) : int'(av);
    y  = o[1] ? int'(av) : int'(bv);
    sx = (x >= 8) ? x - 16 : x;
    sy = (y >= 8) ? y - 16 : y;
    if (o[0]) begin
      ur  = x - y;
      e.c = (x < y);
      sr  = sx - sy;
    end else begin
      ur  = x + y;
      e.c = (ur > 15);
      sr  = sx + sy;
    end
    e.v = (sr > 7) || (sr < -8);
    r = ur & 15;
    if (sat && e.v) r = (sx >= 0) ? 7 : 8;
    e.res = 4'(r);
    e.z   = (r == 0);
    e.n   = e.res[3];
    return e;
  endfunction

  function automatic logic [7:0] f0();
    return {Result0, CarryOut0, Overflow0, Zero0, Negative0};
  endfunction

  function automatic logic [7:0] f1();
    return {Result1, CarryOut1, Overflow1, Zero1, Negative1};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_all();
    logic ir_exp;
    ir_exp = !m_valid || out_ready;
    check("in_ready0", 32'(In_ready0), 32'(ir_exp));
    check("in_ready1", 32'(In_ready1), 32'(ir_exp));
    check("out_valid0", 32'(Out_valid0), 32'(m_valid));
    check("out_valid1", 32'(Out_valid1), 32'(m_valid));
    check("acc0", 32'(Acc0), 32'(m_acc0));
    check("acc1", 32'(Acc1), 32'(m_acc1));
    check("op_count0", 32'(Op_count0), 32'(m_cnt0));
    check("op_count1", 32'(Op_count1), 32'(m_cnt1));
    if (m_valid) begin
      check("sb_depth", 32'(q0.size()), 32'd1);
      if (q0.size() > 0) begin
        check("sb_out0", 32'(f0()), 32'(q0[0]));
        check("sb_out1", 32'(f1()), 32'(q1[0]));
      end
    end
  endtask

  // One clock: predict handshake outcome, advance the model, compare after the edge.
  task automatic tick();
    logic acc_en, cons;
    exp_t e0, e1;
    acc_en = in_valid && (!m_valid || out_ready);
    cons   = m_valid && out_ready;
    e0 = calc(op, a, b, clr ? 4'd0 : m_acc0, 1'b0);
    e1 = calc(op, a, b, clr ? 4'd0 : m_acc1, 1'b1);
    @(posedge clk);
    if (cons) begin
      void'(q0.pop_front());
      void'(q1.pop_front());
      if (m_cnt0 != 255) m_cnt0++;
      if (m_cnt1 != 7) m_cnt1++;
    end
    if (acc_en) begin
      q0.push_back(e0);
      q1.push_back(e1);
    end
    if (acc_en && op[1]) begin
      m_acc0 = e0.res;
      m_acc1 = e1.res;
    end else if (clr) begin
      m_acc0 = 4'd0;
      m_acc1 = 4'd0;
    end
    if (acc_en) m_valid = 1'b1;
    else if (cons) m_valid = 1'b0;
    #1;
    check_all();
  endtask

  task automatic op_step(input logic [1:0] o, input logic [3:0] av, input logic [3:0] bv,
                         input logic c);
    op = o; a = av; b = bv; clr = c; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; clr = 1'b0;
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    m_valid = 1'b0;
    m_acc0 = 4'd0;
    m_acc1 = 4'd0;
    m_cnt0 = 0;
    m_cnt1 = 0;
  endtask

  task automatic check_reset_outputs();
    check("rst_out0", 32'({Out_valid0, f0(), Acc0, Op_count0}), 32'd0);
    check("rst_out1", 32'({Out_valid1, f1(), Acc1, Op_count1}), 32'd0);
    check("rst_in_ready0", 32'(In_ready0), 32'd1);
    check("rst_in_ready1", 32'(In_ready1), 32'd1);
  endtask

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = 2'b00; clr = 1'b0; out_ready = 1'b1;
    model_reset();
    #1 rst_n = 1'b0;
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    op_step(2'b00, 4'd3, 4'd2, 1'b0);
    check("add_3p2_0", 32'(f0()), 32'(8'b0101_0000));
    check("add_3p2_1", 32'(f1()), 32'(8'b0101_0000));
    op_step(2'b00, 4'd8, 4'd9, 1'b0);
    check("add_8p9_0", 32'(f0()), 32'(8'b0001_1100));
    check("add_8p9_sat", 32'(f1()), 32'(8'b1000_1101));
    op_step(2'b01, 4'd5, 4'd6, 1'b0);
    check("sub_5m6", 32'(f0()), 32'(8'b1111_1001));
    op_step(2'b01, 4'd3, 4'd3, 1'b0);
    check("sub_3m3", 32'(f0()), 32'(8'b0000_0010));
    op_step(2'b00, 4'd7, 4'd5, 1'b0);
    check("add_7p5_wrap", 32'(f0()), 32'(8'b1100_0101));
    check("add_7p5_sat", 32'(f1()), 32'(8'b0111_0100));
    op_step(2'b01, 4'd8, 4'd1, 1'b0);
    check("sub_8m1_wrap", 32'(f0()), 32'(8'b0111_0100));
    check("sub_8m1_sat", 32'(f1()), 32'(8'b1000_0101));

    // Clear alone, then accumulate.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_alone", 32'({Acc0, Acc1}), 32'd0);
    op_step(2'b10, 4'd3, 4'd0, 1'b0);
    check("acc_3", 32'(Acc0), 32'd3);
    op_step(2'b10, 4'd3, 4'd0, 1'b0);
    check("acc_6", 32'(Acc0), 32'd6);
    op_step(2'b10, 4'd3, 4'd0, 1'b0);
    check("acc_9_wrap", 32'({Acc0, f0()}), 32'({4'b1001, 8'b1001_0101}));
    check("acc_9_sat", 32'({Acc1, f1()}), 32'({4'b0111, 8'b0111_0100}));
    op_step(2'b11, 4'd1, 4'd0, 1'b0);
    check("accsub_8", 32'({Acc0, f0()}), 32'({4'b1000, 8'b1000_0001}));
    check("accsub_sat6", 32'(Acc1), 32'd6);
    op_step(2'b10, 4'd2, 4'd0, 1'b1);
    check("clr_with_acc", 32'({Acc0, Acc1}), 32'({4'd2, 4'd2}));
    op_step(2'b00, 4'd1, 4'd1, 1'b1);
    check("clr_with_add", 32'({Acc0, Acc1}), 32'd0);

    // Backpressure: first op accepted, then a second op waits while output is held.
    op = 2'b10; a = 4'd1; b = 4'd0; in_valid = 1'b1;
    tick();
    out_ready = 1'b0;
    op = 2'b10; a = 4'd2;
    cnt_snap = m_cnt0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_in_ready", 32'(In_ready0), 32'd0);
      check("bp_frozen", 32'({Out_valid0, Result0, Acc0}), 32'({1'b1, 4'd1, 4'd1}));
      check("bp_count", 32'(Op_count0), 32'(cnt_snap));
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("bp_release", 32'({Out_valid0, Result0, Acc0}), 32'({1'b1, 4'd3, 4'd3}));
    check("bp_count_inc", 32'(Op_count0), 32'(cnt_snap + 1));
    check("cnt_saturate", 32'(Op_count1), 32'd7);

    // Reset in the middle of a pending result.
    op_step(2'b10, 4'd3, 4'd0, 1'b1);
    op_step(2'b10, 4'd3, 4'd0, 1'b0);
    check("pre_rst", 32'({Out_valid0, Acc0}), 32'({1'b1, 4'd6}));
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    op_step(2'b10, 4'd1, 4'd0, 1'b0);
    check("post_rst_acc", 32'({Acc0, Acc1}), 32'({4'd1, 4'd1}));
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
